sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 24 ++
 rtl/sram_read_tracker.sv | 31 +++
 rtl/sram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the frame-buffer SRAM arbiter: geometry defaults,
// ADC FIFO word layout and the coordinate-to-word-address mapping.
package sram_arbiter_pkg;

    localparam int PRECISION_DEF  = 11;
    localparam int PIXEL_SIZE_DEF = 16;

    // ADC FIFO word is {x, y, pixel}
    localparam int ADC_PIX_LSB = 0;
    localparam int ADC_Y_LSB   = PIXEL_SIZE_DEF;
    localparam int ADC_X_LSB   = PIXEL_SIZE_DEF + PRECISION_DEF;

    typedef enum logic {
        WR_ADC = 1'b0,
        WR_SPI = 1'b1
    } writer_e;

    function automatic logic [31:0] coord_to_addr(input logic [31:0] x,
                                                  input logic [31:0] y,
                                                  input logic [31:0] x_res);
        return y * x_res + x;
    endfunction

endpackage

// File: rtl/sram_read_tracker.sv
// Tracks issued reads (valid + out-of-range flag) for LATENCY cycles so the
// response stage knows when SRAM data lands and whether to substitute zero.
module sram_read_tracker #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_valid,
    input  logic issue_oor,
    output logic done_valid,
    output logic done_oor
);

    logic [LATENCY-1:0] valid_r;
    logic [LATENCY-1:0] oor_r;

    // Shift register; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            oor_r   <= '0;
        end else begin
            valid_r <= (valid_r << 1) | LATENCY'(issue_valid);
            oor_r   <= (oor_r << 1) | LATENCY'(issue_valid & issue_oor);
        end
    end

    assign done_valid = valid_r[LATENCY-1];
    assign done_oor   = oor_r[LATENCY-1];

endmodule

// File: rtl/sram_arbiter.sv
// Frame-buffer SRAM arbiter: foreground reads win outright, ADC/SPI writes share
// idle cycles round-robin. Define SRAM_ARBITER_SPI_EN to enable the SPI writer.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int PRECISION    = PRECISION_DEF,
    parameter int PIXEL_SIZE   = PIXEL_SIZE_DEF,
    parameter int X_RES        = 800,
    parameter int Y_RES        = 600,
    parameter int ADDR_WIDTH   = 20,
    parameter int READ_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frozen,
    input  logic [2*PRECISION+PIXEL_SIZE-1:0] adc_pixel_data,
    input  logic                              adc_pixel_ready,
    output logic                              adc_pixel_read,
    input  logic                              spi_active,
    input  logic [PIXEL_SIZE-1:0]             spi_pixel_in,
    input  logic [PRECISION-1:0]              spi_pixel_x,
    input  logic [PRECISION-1:0]              spi_pixel_y,
    output logic                              spi_pixel_read,
    input  logic                              request_active,
    input  logic signed [PRECISION:0]         request_x,
    input  logic signed [PRECISION:0]         request_y,
    output logic                              request_ready,
    output logic [PIXEL_SIZE-1:0]             request_data,
    output logic                              mem_cmd_valid,
    output logic                              mem_cmd_write,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [PIXEL_SIZE-1:0]             mem_wdata,
    input  logic [PIXEL_SIZE-1:0]             mem_rdata,
    output logic [15:0]                       write_stall_count
);

    logic [PRECISION-1:0]  adc_x_s, adc_y_s, rd_x_s, rd_y_s;
    logic [PIXEL_SIZE-1:0] adc_pix_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s, adc_addr_s, spi_addr_s;
    logic rd_in_range_s, adc_in_range_s;
    logic rd_cmd_s, adc_elig_s, adc_drop_s, spi_elig_s;
    logic adc_grant_s, spi_grant_s, stall_s;
    logic trk_valid_s, trk_oor_s;

    logic                  request_ready_r;
    logic [PIXEL_SIZE-1:0] request_data_r;
    logic [15:0]           stall_cnt_r;
    writer_e               last_wr_r;

    assign adc_x_s   = adc_pixel_data[PIXEL_SIZE+PRECISION +: PRECISION];
    assign adc_y_s   = adc_pixel_data[PIXEL_SIZE +: PRECISION];
    assign adc_pix_s = adc_pixel_data[0 +: PIXEL_SIZE];
    assign rd_x_s    = request_x[PRECISION-1:0];
    assign rd_y_s    = request_y[PRECISION-1:0];

    assign rd_in_range_s  = !request_x[PRECISION] && !request_y[PRECISION]
                          && (32'(rd_x_s) < 32'(X_RES)) && (32'(rd_y_s) < 32'(Y_RES));
    assign adc_in_range_s = (32'(adc_x_s) < 32'(X_RES)) && (32'(adc_y_s) < 32'(Y_RES));

    assign rd_addr_s  = ADDR_WIDTH'(coord_to_addr(32'(rd_x_s), 32'(rd_y_s), 32'(X_RES)));
    assign adc_addr_s = ADDR_WIDTH'(coord_to_addr(32'(adc_x_s), 32'(adc_y_s), 32'(X_RES)));
    assign spi_addr_s = ADDR_WIDTH'(coord_to_addr(32'(spi_pixel_x), 32'(spi_pixel_y), 32'(X_RES)));

`ifdef SRAM_ARBITER_SPI_EN
    assign spi_elig_s     = rst_n & spi_active;
    assign spi_pixel_read = spi_grant_s;
`else
    logic spi_unused_s;
    assign spi_unused_s   = spi_active;
    assign spi_elig_s     = 1'b0;
    assign spi_pixel_read = 1'b0;
`endif

    // Read priority, write eligibility and round-robin grant. A frozen or
    // off-screen ADC pixel is drained without touching the bus, so it is not
    // write-eligible and does not block an SPI grant in the same cycle.
    always_comb begin
        rd_cmd_s    = rst_n & request_active & rd_in_range_s;
        adc_elig_s  = rst_n & adc_pixel_ready & adc_in_range_s & ~frozen;
        adc_drop_s  = rst_n & adc_pixel_ready & ~rd_cmd_s & (frozen | ~adc_in_range_s);
        adc_grant_s = 1'b0;
        spi_grant_s = 1'b0;
        if (rd_cmd_s) begin
            adc_grant_s = 1'b0;
            spi_grant_s = 1'b0;
        end else if (adc_elig_s && spi_elig_s) begin
            if (last_wr_r == WR_ADC) begin
                spi_grant_s = 1'b1;
            end else begin
                adc_grant_s = 1'b1;
            end
        end else begin
            adc_grant_s = adc_elig_s;
            spi_grant_s = spi_elig_s;
        end
        stall_s = (adc_elig_s & ~adc_grant_s) | (spi_elig_s & ~spi_grant_s);
    end

    // Bus address/data steering for the granted command.
    always_comb begin
        mem_addr  = rd_addr_s;
        mem_wdata = adc_pix_s;
        if (adc_grant_s) begin
            mem_addr  = adc_addr_s;
            mem_wdata = adc_pix_s;
        end else if (spi_grant_s) begin
            mem_addr  = spi_addr_s;
            mem_wdata = spi_pixel_in;
        end else begin
            mem_addr  = rd_addr_s;
            mem_wdata = adc_pix_s;
        end
    end

    assign mem_cmd_valid  = rd_cmd_s | adc_grant_s | spi_grant_s;
    assign mem_cmd_write  = adc_grant_s | spi_grant_s;
    assign adc_pixel_read = adc_grant_s | adc_drop_s;

    sram_read_tracker #(
        .LATENCY(READ_LATENCY)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(request_active),
        .issue_oor  (~rd_in_range_s),
        .done_valid (trk_valid_s),
        .done_oor   (trk_oor_s)
    );

    // Response stage: capture SRAM data (zero for off-screen) as the read retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            request_ready_r <= 1'b0;
            request_data_r  <= '0;
        end else begin
            request_ready_r <= trk_valid_s;
            if (trk_valid_s) begin
                request_data_r <= trk_oor_s ? '0 : mem_rdata;
            end else begin
                request_data_r <= request_data_r;
            end
        end
    end

    // Round-robin pointer (reset favours ADC) and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_r   <= WR_SPI;
            stall_cnt_r <= 16'd0;
        end else begin
            if (adc_grant_s) begin
                last_wr_r <= WR_ADC;
            end else if (spi_grant_s) begin
                last_wr_r <= WR_SPI;
            end else begin
                last_wr_r <= last_wr_r;
            end
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign request_ready     = request_ready_r;
    assign request_data      = request_data_r;
    assign write_stall_count = stall_cnt_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: read responses are queued at issue time
// and matched when request_ready fires; command strobes are checked per cycle.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int XR = 800;
    localparam int YR = 600;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frozen;
    logic [37:0]        adc_pixel_data;
    logic               adc_pixel_ready;
    logic               adc_pixel_read;
    logic               spi_active;
    logic [15:0]        spi_pixel_in;
    logic [10:0]        spi_pixel_x, spi_pixel_y;
    logic               spi_pixel_read;
    logic               request_active;
    logic signed [11:0] request_x, request_y;
    logic               request_ready;
    logic [15:0]        request_data;
    logic               mem_cmd_valid, mem_cmd_write;
    logic [19:0]        mem_addr;
    logic [15:0]        mem_wdata, mem_rdata;
    logic [15:0]        write_stall_count;

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .frozen(frozen),
        .adc_pixel_data(adc_pixel_data), .adc_pixel_ready(adc_pixel_ready),
        .adc_pixel_read(adc_pixel_read),
        .spi_active(spi_active), .spi_pixel_in(spi_pixel_in),
        .spi_pixel_x(spi_pixel_x), .spi_pixel_y(spi_pixel_y),
        .spi_pixel_read(spi_pixel_read),
        .request_active(request_active), .request_x(request_x), .request_y(request_y),
        .request_ready(request_ready), .request_data(request_data),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_write(mem_cmd_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .write_stall_count(write_stall_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pat(input logic [19:0] a);
        return a[15:0] ^ 16'hAD8E;
    endfunction

    // SRAM model: data for a read command appears two cycles later
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [19:0] p1_a = 20'd0, p2_a = 20'd0;
    always @(posedge clk) begin
        p1_v <= mem_cmd_valid & ~mem_cmd_write;
        p1_a <= mem_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign mem_rdata = p2_v ? pat(p2_a) : 16'h5A5A;

    typedef struct {
        logic [15:0] data;
        int          due;
    } rsp_t;
    rsp_t        exp_q[$];
    rsp_t        rsp;
    logic [15:0] hold_data = 16'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_data = 16'h0;
        end else if (request_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 32'(request_ready), 32'd0);
            end else begin
                rsp = exp_q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(rsp.due));
                check("rd_data", 32'(request_data), 32'(rsp.data));
                hold_data = rsp.data;
            end
        end else begin
            check("data_hold", 32'(request_data), 32'(hold_data));
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                check("ready_missing", 32'(request_ready), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    logic [37:0] adc_q[$];
    logic        s_valid, s_write, s_adc_rd, s_spi_rd;
    logic [19:0] s_addr;
    logic [15:0] s_wdata;

    task automatic adc_refresh();
        adc_pixel_ready = (adc_q.size() != 0);
        adc_pixel_data  = (adc_q.size() != 0) ? adc_q[0] : 38'd0;
    endtask

    task automatic adc_push(input int x, input int y, input logic [15:0] pix);
        adc_q.push_back((38'(x) << ADC_X_LSB) | (38'(y) << ADC_Y_LSB) | (38'(pix) << ADC_PIX_LSB));
        adc_refresh();
    endtask

    // Sample this cycle's strobes mid-cycle, then advance past the next edge.
    task automatic tick();
        @(negedge clk);
        s_valid  = mem_cmd_valid;
        s_write  = mem_cmd_write;
        s_adc_rd = adc_pixel_read;
        s_spi_rd = spi_pixel_read;
        s_addr   = mem_addr;
        s_wdata  = mem_wdata;
        @(posedge clk);
        #1;
        if (s_adc_rd && adc_q.size() != 0) void'(adc_q.pop_front());
        adc_refresh();
    endtask

    task automatic do_read(input int x, input int y);
        rsp_t e;
        request_active = 1'b1;
        request_x      = 12'(x);
        request_y      = 12'(y);
        e.due  = cyc + 3;
        e.data = (x >= 0 && y >= 0 && x < XR && y < YR) ? pat(20'(y * XR + x)) : 16'h0;
        exp_q.push_back(e);
    endtask

    typedef struct {
        int x;
        int y;
    } xy_t;
    xy_t rd_tab[6] = '{'{799, 599}, '{800, 0}, '{0, 600}, '{0, 0}, '{-5, -5}, '{123, 456}};

    int pops, writes, adc_idx;
    logic exp_adc;

    initial begin
        rst_n = 1'b0; frozen = 1'b0; spi_active = 1'b0; spi_pixel_in = 16'h0;
        spi_pixel_x = 11'd0; spi_pixel_y = 11'd0;
        request_active = 1'b1; request_x = 12'sd3; request_y = 12'sd2;
        adc_push(4, 4, 16'h4444);
        repeat (2) tick();
        check("rst_cmd_valid", 32'(s_valid), 32'd0);
        check("rst_cmd_write", 32'(s_write), 32'd0);
        check("rst_adc_read", 32'(s_adc_rd), 32'd0);
        check("rst_spi_read", 32'(s_spi_rd), 32'd0);
        check("rst_ready", 32'(request_ready), 32'd0);
        check("rst_data", 32'(request_data), 32'd0);
        check("rst_stall", 32'(write_stall_count), 32'd0);
        request_active = 1'b0;
        adc_q.delete();
        adc_refresh();
        rst_n = 1'b1;
        tick();

        do_read(3, 2);
        tick();
        check("rd_valid", 32'(s_valid), 32'd1);
        check("rd_write", 32'(s_write), 32'd0);
        check("rd_addr", 32'(s_addr), 32'd1603);
        check("rd_expect_abcd", 32'(exp_q[0].data), 32'h0000ABCD);
        request_active = 1'b0;
        repeat (4) tick();

        do_read(-1, 5);
        tick();
        check("oor_no_cmd", 32'(s_valid), 32'd0);
        request_active = 1'b0;
        repeat (4) tick();

        foreach (rd_tab[i]) begin
            do_read(rd_tab[i].x, rd_tab[i].y);
            tick();
            if (rd_tab[i].x >= 0 && rd_tab[i].y >= 0 && rd_tab[i].x < XR && rd_tab[i].y < YR) begin
                check("pipe_valid", 32'(s_valid), 32'd1);
                check("pipe_addr", 32'(s_addr), 32'(rd_tab[i].y * XR + rd_tab[i].x));
            end else begin
                check("pipe_oor", 32'(s_valid), 32'd0);
            end
        end
        request_active = 1'b0;
        repeat (5) tick();

        adc_push(10, 10, 16'h1234);
        for (int k = 0; k < 5; k++) begin
            do_read(0, 0);
            tick();
            check("starve_no_pop", 32'(s_adc_rd), 32'd0);
            check("starve_read", 32'({s_valid, s_write}), 32'd2);
            check("stall_count", 32'(write_stall_count), 32'(k + 1));
        end
        request_active = 1'b0;
        tick();
        check("adc_wr_strobes", 32'({s_valid, s_write, s_adc_rd, s_spi_rd}), 32'hE);
        check("adc_wr_addr", 32'(s_addr), 32'd8010);
        check("adc_wr_data", 32'(s_wdata), 32'h1234);
        check("stall_after_grant", 32'(write_stall_count), 32'd5);
        repeat (4) tick();

        adc_push(800, 3, 16'h7777);
        tick();
        check("adc_oor_pop", 32'(s_adc_rd), 32'd1);
        check("adc_oor_no_cmd", 32'(s_valid), 32'd0);

        frozen = 1'b1;
        for (int i = 0; i < 5; i++) adc_push(i, 1, 16'(16'h2000 + i));
        pops = 0;
        writes = 0;
        for (int i = 0; i < 20 && adc_q.size() != 0; i++) begin
            tick();
            pops   += int'(s_adc_rd);
            writes += int'(s_valid & s_write);
        end
        check("frozen_pops", 32'(pops), 32'd5);
        check("frozen_writes", 32'(writes), 32'd0);
        frozen = 1'b0;

`ifdef SRAM_ARBITER_SPI_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) adc_push(i, 0, 16'(16'h1000 + i));
        spi_active = 1'b1; spi_pixel_in = 16'hBEEF; spi_pixel_x = 11'd7; spi_pixel_y = 11'd1;
        adc_idx = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_adc = ((k % 2) == 0);
            check("rr_adc", 32'(s_adc_rd), 32'(exp_adc));
            check("rr_spi", 32'(s_spi_rd), 32'(!exp_adc));
            check("rr_wdata", 32'(s_wdata), exp_adc ? 32'(16'h1000 + adc_idx) : 32'h0000BEEF);
            check("rr_addr", 32'(s_addr), exp_adc ? 32'(adc_idx) : 32'd807);
            if (exp_adc) adc_idx++;
        end
        spi_active = 1'b0;
        repeat (3) tick();
`else
        spi_active = 1'b1; spi_pixel_in = 16'hBEEF;
        adc_push(1, 1, 16'h0A0A);
        adc_push(2, 1, 16'h0B0B);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("nospi_spi_read", 32'(s_spi_rd), 32'd0);
            check("nospi_adc_wr", 32'({s_valid, s_write, s_adc_rd}), 32'd7);
            check("nospi_wdata", 32'(s_wdata), k == 0 ? 32'h0A0A : 32'h0B0B);
        end
        spi_active = 1'b0;
        tick();
`endif

        do_read(3, 2);
        tick();
        request_active = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_cmd", 32'({s_valid, s_write, s_adc_rd, s_spi_rd}), 32'd0);
        check("midrst_ready", 32'(request_ready), 32'd0);
        check("midrst_data", 32'(request_data), 32'd0);
        check("midrst_stall", 32'(write_stall_count), 32'd0);
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_ready", 32'(request_ready), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
